vga_map_scanner: RTL and testbench
==================================

// Module: vga_map_scanner
// PURPOSE
//   Pixel-timing front end for the map renderer: generates 640x480@60 VGA sync and scan position
//   from the system clock, and converts it to map-local coordinates (map_x, map_y, map_on).
//   The map renderer consumes these and returns rgb. frame_tick paces game/camera updates.
//   All outputs are registered and mutually aligned.
// PARAMETERS
//   PHY_WIDTH     16   width of map_x / map_y
//   PIX_DIV       4    clk cycles per pixel (100 MHz -> 25 MHz)
//   MAP_X_OFFSET  140  first screen column of map window
//   MAP_Y_OFFSET  0    first screen row of map window
//   MAP_WIDTH_X   480  map window width, pixels
//   MAP_HEIGHT_Y  480  map window height, pixels
//   H_ACTIVE/H_FP/H_SYNC/H_BP  640/16/96/48   horizontal timing, pixels
//   V_ACTIVE/V_FP/V_SYNC/V_BP  480/10/2/33    vertical timing, lines
// PORTS
//   clk         in   1          system clock
//   rst_n       in   1          asynchronous reset, active low
//   pixel_tick  out  1          one-clk strobe, once per PIX_DIV clks
//   hsync       out  1          horizontal sync, active low
//   vsync       out  1          vertical sync, active low
//   video_on    out  1          scan position inside 640x480 active area
//   pixel_x     out  10         screen column of current pixel (0..799)
//   pixel_y     out  10         screen row of current pixel (0..524)
//   map_on      out  1          current pixel inside map window
//   map_x       out  PHY_WIDTH  pixel_x - MAP_X_OFFSET when map_on, else 0
//   map_y       out  PHY_WIDTH  pixel_y - MAP_Y_OFFSET when map_on, else 0
//   frame_tick  out  1          one-clk pulse at start of vertical blank
// BEHAVIOUR
// - Reset (async, rst_n=0): div_cnt=0, h_cnt=0, v_cnt=0.
//   Outputs: pixel_tick=0, hsync=1, vsync=1, video_on=0, pixel_x=0, pixel_y=0, map_on=0,
//   map_x=0, map_y=0, frame_tick=0. Takes effect immediately, also mid-frame.
// - Divider: div_cnt counts 0..PIX_DIV-1 and wraps. pixel_tick is registered; it is 1 in the
//   clk after div_cnt==PIX_DIV-1. First pixel_tick comes PIX_DIV clks after reset release.
// - Counters advance only when div_cnt==PIX_DIV-1.
//   h_cnt: 0..799, wraps to 0. v_cnt increments on h wrap; 0..524, wraps to 0 when h and v wrap together.
// - Output registers load in the same clk the counters advance, from the pre-advance (h_cnt, v_cnt).
//   This gives one pixel of latency, and every output changes in the same clk as pixel_tick rises.
//   Outputs are held between ticks.
// - Decode, with h=h_cnt and v=v_cnt:
//     video_on = h<640 && v<480
//     hsync    = !(656<=h<752)
//     vsync    = !(490<=v<492)
//     map_on   = video_on && MAP_X_OFFSET<=h<MAP_X_OFFSET+MAP_WIDTH_X
//                && MAP_Y_OFFSET<=v<MAP_Y_OFFSET+MAP_HEIGHT_Y
// - map_x/map_y: zero-extended unsigned subtraction, evaluated only when map_on. Forced to 0
//   otherwise, so no wrap or negative value is ever emitted.
// - frame_tick: 1 for exactly one clk, the clk in which outputs load h=0, v=V_ACTIVE.
//   That is once per frame = 800*525*PIX_DIV = 1,680,000 clks.
// - All boundaries use derived localparams; the window must lie inside the active area
//   (checked by an elaboration-time assertion).
// TESTING
// 1. Hold rst_n=0 for 10 clks -> all outputs at reset values.
//    Release -> first pixel_tick at clk 4, then one every 4 clks, with pixel_x=0, pixel_y=0, video_on=1.
// 2. Run one line -> hsync low for exactly 96 ticks, starting at pixel_x=656.
//    video_on high for 640 ticks. Line period is 800 ticks = 3200 clks.
// 3. Scan row 0 -> pixel_x=139: map_on=0, map_x=0. pixel_x=140: map_on=1, map_x=0.
//    pixel_x=619: map_x=479. pixel_x=620: map_on=0, map_x=0.
// 4. Run a full frame -> vsync low for 2 lines at pixel_y 490..491.
//    After pixel (799,524) the next pixel is (0,0). frame_tick fires once; the next fires 1,680,000 clks later.
// 5. Row 479 vs 480 at pixel_x=300 -> map_y=479 with map_on=1, then map_on=0 and map_y=0.
//    frame_tick coincides with pixel_y=480, pixel_x=0.
// 6. Assert rst_n at pixel (400,200) mid-tick -> outputs reset asynchronously, without waiting for clk.
//    After release, scan restarts at (0,0) with no glitch pulse on hsync or vsync.

Source files
------------

// File: rtl/vga_map_scanner.sv
// vga_map_scanner
//   Pixel-timing front end for the map renderer. Divides the system clock down
//   to the pixel rate, scans an 800x525 (default) VGA raster and emits sync,
//   screen position and map-window-local coordinates. Every output is a
//   register loaded on the same clk as pixel_tick, so all of them stay
//   mutually aligned and are held steady between ticks.
//
// Ports
//   clk         in   system clock
//   rst_n       in   asynchronous reset, active low
//   pixel_tick  out  one-clk strobe, once per PIX_DIV clks
//   hsync       out  horizontal sync, active low
//   vsync       out  vertical sync, active low
//   video_on    out  scan position inside the active area
//   pixel_x     out  screen column of current pixel
//   pixel_y     out  screen row of current pixel
//   map_on      out  current pixel inside the map window
//   map_x       out  column relative to the map window (0 outside it)
//   map_y       out  row relative to the map window (0 outside it)
//   frame_tick  out  one-clk pulse at the start of vertical blank
module vga_map_scanner #(
  parameter int PHY_WIDTH    = 16,
  parameter int PIX_DIV      = 4,
  parameter int MAP_X_OFFSET = 140,
  parameter int MAP_Y_OFFSET = 0,
  parameter int MAP_WIDTH_X  = 480,
  parameter int MAP_HEIGHT_Y = 480,
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 pixel_tick,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 video_on,
  output logic [9:0]           pixel_x,
  output logic [9:0]           pixel_y,
  output logic                 map_on,
  output logic [PHY_WIDTH-1:0] map_x,
  output logic [PHY_WIDTH-1:0] map_y,
  output logic                 frame_tick
);

  localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] MAP_X_OFF  = 10'(MAP_X_OFFSET);
  localparam logic [9:0] MAP_Y_OFF  = 10'(MAP_Y_OFFSET);
  localparam logic [9:0] MAP_W      = 10'(MAP_WIDTH_X);
  localparam logic [9:0] MAP_H      = 10'(MAP_HEIGHT_Y);

  // The map window has to sit entirely inside the visible area.
  if (MAP_X_OFFSET < 0 || MAP_Y_OFFSET < 0 || MAP_WIDTH_X < 1 || MAP_HEIGHT_Y < 1 ||
      MAP_X_OFFSET + MAP_WIDTH_X > H_ACTIVE || MAP_Y_OFFSET + MAP_HEIGHT_Y > V_ACTIVE ||
      PIX_DIV < 1) begin : g_bad_window
    $error("vga_map_scanner: map window outside active area or bad PIX_DIV");
  end

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic             adv;

  logic             video_d;
  logic             hsync_d;
  logic             vsync_d;
  logic             map_on_d;
  logic [10:0]      rel_x;
  logic [10:0]      rel_y;
  logic [PHY_WIDTH-1:0] map_x_d;
  logic [PHY_WIDTH-1:0] map_y_d;
  logic             frame_d;

  assign adv = (div_cnt == DIV_LAST);

  // Decode of the pre-advance position. The window test uses an 11-bit
  // subtraction: the borrow bit flags positions left of / above the window,
  // which also keeps a zero offset from producing a constant comparison.
  always_comb begin
    video_d  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hsync_d  = !((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END));
    vsync_d  = !((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END));
    rel_x    = {1'b0, h_cnt} - {1'b0, MAP_X_OFF};
    rel_y    = {1'b0, v_cnt} - {1'b0, MAP_Y_OFF};
    map_on_d = video_d && !rel_x[10] && (rel_x[9:0] < MAP_W)
                       && !rel_y[10] && (rel_y[9:0] < MAP_H);
    map_x_d  = '0;
    map_y_d  = '0;
    if (map_on_d) begin
      map_x_d = PHY_WIDTH'(rel_x[9:0]);
      map_y_d = PHY_WIDTH'(rel_y[9:0]);
    end
    frame_d  = (h_cnt == 10'd0) && (v_cnt == V_ACT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      h_cnt      <= '0;
      v_cnt      <= '0;
      pixel_tick <= 1'b0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      video_on   <= 1'b0;
      pixel_x    <= '0;
      pixel_y    <= '0;
      map_on     <= 1'b0;
      map_x      <= '0;
      map_y      <= '0;
      frame_tick <= 1'b0;
    end else begin
      pixel_tick <= adv;
      frame_tick <= 1'b0;
      div_cnt    <= adv ? '0 : div_cnt + DIV_W'(1);
      if (adv) begin
        // Outputs take the position the counters hold before advancing.
        hsync      <= hsync_d;
        vsync      <= vsync_d;
        video_on   <= video_d;
        pixel_x    <= h_cnt;
        pixel_y    <= v_cnt;
        map_on     <= map_on_d;
        map_x      <= map_x_d;
        map_y      <= map_y_d;
        frame_tick <= frame_d;
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_map_scanner.sv
// tb_vga_map_scanner
//   Two instances: u_full with default 640x480 timing (reset, first lines,
//   row-0 window edges) and u_small with a shrunken raster so whole frames
//   fit in a short run. A reference model derives every output from the
//   number of clk edges since reset release.
module tb_vga_map_scanner;

  localparam int S_D = 3;
  localparam int S_HA = 40, S_HFP = 4, S_HS = 6, S_HBP = 5;
  localparam int S_VA = 20, S_VFP = 3, S_VS = 2, S_VBP = 4;
  localparam int S_MXO = 8, S_MW = 20, S_MYO = 3, S_MH = 12;
  localparam int S_FRAME = (S_HA + S_HFP + S_HS + S_HBP) * (S_VA + S_VFP + S_VS + S_VBP) * S_D;

  localparam logic [57:0] RESET_VEC = {1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 16'd0, 16'd0, 1'b0};

  logic clk = 1'b0;
  logic rst_full_n = 1'b0;
  logic rst_small_n = 1'b0;
  logic chk_en = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   k_full = 0;
  int   k_small = 0;

  logic f_pixel_tick, f_hsync, f_vsync, f_video_on, f_map_on, f_frame_tick;
  logic [9:0] f_pixel_x, f_pixel_y;
  logic [15:0] f_map_x, f_map_y;
  logic s_pixel_tick, s_hsync, s_vsync, s_video_on, s_map_on, s_frame_tick;
  logic [9:0] s_pixel_x, s_pixel_y;
  logic [15:0] s_map_x, s_map_y;
  logic [57:0] f_vec, s_vec;

  always #5 clk = ~clk;

  vga_map_scanner u_full (
    .clk(clk), .rst_n(rst_full_n), .pixel_tick(f_pixel_tick), .hsync(f_hsync),
    .vsync(f_vsync), .video_on(f_video_on), .pixel_x(f_pixel_x), .pixel_y(f_pixel_y),
    .map_on(f_map_on), .map_x(f_map_x), .map_y(f_map_y), .frame_tick(f_frame_tick)
  );

  vga_map_scanner #(
    .PIX_DIV(S_D), .MAP_X_OFFSET(S_MXO), .MAP_Y_OFFSET(S_MYO),
    .MAP_WIDTH_X(S_MW), .MAP_HEIGHT_Y(S_MH),
    .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP)
  ) u_small (
    .clk(clk), .rst_n(rst_small_n), .pixel_tick(s_pixel_tick), .hsync(s_hsync),
    .vsync(s_vsync), .video_on(s_video_on), .pixel_x(s_pixel_x), .pixel_y(s_pixel_y),
    .map_on(s_map_on), .map_x(s_map_x), .map_y(s_map_y), .frame_tick(s_frame_tick)
  );

  assign f_vec = {f_pixel_tick, f_hsync, f_vsync, f_video_on, f_pixel_x, f_pixel_y,
                  f_map_on, f_map_x, f_map_y, f_frame_tick};
  assign s_vec = {s_pixel_tick, s_hsync, s_vsync, s_video_on, s_pixel_x, s_pixel_y,
                  s_map_on, s_map_x, s_map_y, s_frame_tick};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected outputs after k clk edges since reset release: the t-th pixel
  // tick lands on edge t*d and shows raster position t-1 (mod frame size).
  function automatic logic [57:0] model(input int k, input int d,
      input int ha, input int hfp, input int hs, input int hbp,
      input int va, input int vfp, input int vs, input int vbp,
      input int mxo, input int mw, input int myo, input int mh);
    int ht, vt, t, p, h, v, mx, my;
    logic vo, hsn, vsn, mo, tick, ft;
    if (k < d) return RESET_VEC;
    ht = ha + hfp + hs + hbp;
    vt = va + vfp + vs + vbp;
    t  = k / d;
    p  = (t - 1) % (ht * vt);
    h  = p % ht;
    v  = p / ht;
    vo   = (h < ha) && (v < va);
    hsn  = !((h >= ha + hfp) && (h < ha + hfp + hs));
    vsn  = !((v >= va + vfp) && (v < va + vfp + vs));
    mo   = vo && (h >= mxo) && (h < mxo + mw) && (v >= myo) && (v < myo + mh);
    mx   = mo ? h - mxo : 0;
    my   = mo ? v - myo : 0;
    tick = (k % d) == 0;
    ft   = tick && (h == 0) && (v == va);
    return {tick, hsn, vsn, vo, 10'(h), 10'(v), mo, 16'(mx), 16'(my), ft};
  endfunction

  always @(posedge clk or negedge rst_full_n)
    if (!rst_full_n) k_full <= 0; else k_full <= k_full + 1;
  always @(posedge clk or negedge rst_small_n)
    if (!rst_small_n) k_small <= 0; else k_small <= k_small + 1;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("full", {6'd0, f_vec},
          {6'd0, model(k_full, 4, 640, 16, 96, 48, 480, 10, 2, 33, 140, 480, 0, 480)});
      chk("small", {6'd0, s_vec},
          {6'd0, model(k_small, S_D, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP,
                       S_MXO, S_MW, S_MYO, S_MH)});
    end
  end

  // Asynchronous reset in the middle of a clk high phase, checked before the
  // next clk edge, then released on a falling edge after a short hold.
  task automatic async_reset_small(input int hold);
    @(posedge clk);
    #2 rst_small_n = 1'b0;
    #1 chk("async_small", {6'd0, s_vec}, {6'd0, RESET_VEC});
    repeat (hold) @(posedge clk);
    @(negedge clk);
    rst_small_n = 1'b1;
  endtask

  initial begin
    int first_tick, hs_low, hs_start, vo_cnt, c0, c1;
    bit got_ft;

    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("reset_full", {6'd0, f_vec}, {6'd0, RESET_VEC});
    chk("reset_small", {6'd0, s_vec}, {6'd0, RESET_VEC});
    rst_full_n  = 1'b1;
    rst_small_n = 1'b1;

    // One full-size line: first tick latency, hsync/video widths, row-0 window edges.
    first_tick = 0; hs_low = 0; hs_start = -1; vo_cnt = 0;
    for (int i = 1; i <= 3200; i++) begin
      @(negedge clk);
      if (f_pixel_tick) begin
        if (first_tick == 0) begin
          first_tick = i;
          chk("first_pos", {44'd0, f_video_on, f_pixel_x, f_pixel_y}, {44'd0, 1'b1, 20'd0});
        end
        if (!f_hsync) begin
          hs_low++;
          if (hs_start < 0) hs_start = int'(f_pixel_x);
        end
        if (f_video_on) vo_cnt++;
        if (f_pixel_x == 10'd139) chk("x139", {47'd0, f_map_on, f_map_x}, {47'd0, 1'b0, 16'd0});
        if (f_pixel_x == 10'd140) chk("x140", {47'd0, f_map_on, f_map_x}, {47'd0, 1'b1, 16'd0});
        if (f_pixel_x == 10'd619) chk("x619", {47'd0, f_map_on, f_map_x}, {47'd0, 1'b1, 16'd479});
        if (f_pixel_x == 10'd620) chk("x620", {47'd0, f_map_on, f_map_x}, {47'd0, 1'b0, 16'd0});
      end
    end
    chk("first_tick", 64'(first_tick), 64'd4);
    chk("hsync_width", 64'(hs_low), 64'd96);
    chk("hsync_start", 64'(hs_start), 64'd656);
    chk("video_width", 64'(vo_cnt), 64'd640);

    // Random mid-line asynchronous reset of the full-size instance.
    repeat ($urandom_range(50, 3000)) @(posedge clk);
    #2 rst_full_n = 1'b0;
    #1 chk("async_full", {6'd0, f_vec}, {6'd0, RESET_VEC});
    repeat ($urandom_range(1, 6)) @(posedge clk);
    @(negedge clk);
    rst_full_n = 1'b1;
    repeat ($urandom_range(200, 1200)) @(posedge clk);

    // Small raster: frame_tick position and period across two frames.
    async_reset_small($urandom_range(1, 5));
    c0 = 0; c1 = 0;
    for (int n = 0; n < 2; n++) begin
      got_ft = 1'b0;
      for (int i = 0; i < S_FRAME + 100 && !got_ft; i++) begin
        @(negedge clk);
        if (s_frame_tick) begin
          got_ft = 1'b1;
          chk("ft_pos", {44'd0, s_pixel_x, s_pixel_y}, {44'd0, 10'd0, 10'(S_VA)});
          if (n == 0) c0 = k_small; else c1 = k_small;
        end
      end
      chk("ft_seen", 64'(got_ft), 64'd1);
    end
    chk("ft_period", 64'(c1 - c0), 64'(S_FRAME));

    // Random resets at random points of the small frame.
    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(100, S_FRAME + 500)) @(posedge clk);
      async_reset_small($urandom_range(1, 8));
    end
    repeat (S_FRAME + 50) @(posedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
